sgd_rd_x_from_memory: RTL and testbench

Loads a model vector x from host memory into the distributed on-chip x memory banks before or between SGD epochs. The block issues one DMA read command covering the whole model, accepts the returned 512-bit beats, and assembles every four beats into one 2048-bit bank word. It writes each bank word into the engine's x memory, so the engines can resume with a host-supplied model. It sits between the host DMA read channel and the per-engine x memories, mirroring the x write-back path.

---
 rtl/sgd_defines.sv | 30 +++
 rtl/x_beat_packer.sv | 88 ++++++++
 rtl/sgd_rd_x_from_memory.sv | 173 +++++++++++++++++
 tb/tb_sgd_rd_x_from_memory.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgd_defines.sv
// Shared SGD engine geometry and FSM encodings used by the
// x-memory load and write-back paths.
package sgd_defines;

  localparam int ENGINE_NUM        = 8;
  localparam int NUM_BITS_PER_BANK = 64;
  localparam int DIS_X_BIT_DEPTH   = 9;

  localparam int BEAT_BITS         = 512;
  localparam int BEAT_BYTES_LOG2   = 6;
  localparam int FEATS_PER_BANK    = 64;

  localparam int S_IDLE = 0;
  localparam int S_CMD  = 1;
  localparam int S_DATA = 2;
  localparam int S_DONE = 3;

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_CMD  = 4'b0010;
  localparam logic [3:0] ST_DATA = 4'b0100;
  localparam logic [3:0] ST_DONE = 4'b1000;

  function automatic logic [31:0] ceil_div(
    input logic [31:0] n,
    input logic [31:0] d
  );
    return (n / d) + (((n % d) != 32'd0) ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/x_beat_packer.sv
// Packs four DMA beats into one bank word and emits the
// one-hot bank write strobe with its row address.
module x_beat_packer #(
  parameter int ENGINE_NUM   = 8,
  parameter int BANK_BITS    = 2048,
  parameter int X_ADDR_WIDTH = 9,
  parameter int BEAT_BITS    = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    beat_acc,
  input  logic [BEAT_BITS-1:0]    beat_data,
  output logic [ENGINE_NUM-1:0]   wr_en,
  output logic [X_ADDR_WIDTH-1:0] wr_addr,
  output logic [BANK_BITS-1:0]    wr_data
);

  localparam int BPW = BANK_BITS / BEAT_BITS;
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int EW  = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
  localparam int AW  = X_ADDR_WIDTH;

  logic [IW-1:0]         inner_q, inner_d;
  logic [EW-1:0]         engine_q, engine_d;
  logic [AW-1:0]         row_q, row_d;
  logic [BANK_BITS-1:0]  asm_q, asm_d;
  logic [ENGINE_NUM-1:0] wr_en_q, wr_en_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [BANK_BITS-1:0]  wr_data_q, wr_data_d;

  always_comb begin
    inner_d   = inner_q;
    engine_d  = engine_q;
    row_d     = row_q;
    asm_d     = asm_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (clear) begin
      inner_d  = '0;
      engine_d = '0;
      row_d    = '0;
    end else if (beat_acc) begin
      // beat k of a group lands in slice k, beat 0 lowest
      asm_d[inner_q*BEAT_BITS +: BEAT_BITS] = beat_data;
      if (inner_q == IW'(BPW-1)) begin
        inner_d            = '0;
        wr_en_d[engine_q]  = 1'b1;
        wr_addr_d          = row_q;
        wr_data_d          = asm_d;
        if (engine_q == EW'(ENGINE_NUM-1)) begin
          engine_d = '0;
          row_d    = row_q + AW'(1);
        end else begin
          engine_d = engine_q + EW'(1);
        end
      end else begin
        inner_d = inner_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inner_q   <= '0;
      engine_q  <= '0;
      row_q     <= '0;
      asm_q     <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      inner_q   <= inner_d;
      engine_q  <= engine_d;
      row_q     <= row_d;
      asm_q     <= asm_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: rtl/sgd_rd_x_from_memory.sv
// Loads model x from host memory via one DMA read and
// scatters the assembled bank words into the x memories.
module sgd_rd_x_from_memory #(
  parameter int ENGINE_NUM   = sgd_defines::ENGINE_NUM,
  parameter int BANK_BITS    = sgd_defines::NUM_BITS_PER_BANK * 32,
  parameter int X_ADDR_WIDTH = sgd_defines::DIS_X_BIT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    started,
  input  logic [63:0]             addr_model,
  input  logic [31:0]             dimension,
  input  logic                    load_x_en,
  output logic                    load_x_done,
  output logic                    x_data_rd_start,
  output logic [63:0]             x_data_rd_addr,
  output logic [31:0]             x_data_rd_length,
  input  logic [511:0]            x_data_in,
  input  logic                    x_data_in_valid,
  output logic                    x_data_in_ready,
  output logic [ENGINE_NUM-1:0]   x_mem_wr_en,
  output logic [X_ADDR_WIDTH-1:0] x_mem_wr_addr,
  output logic [BANK_BITS-1:0]    x_mem_wr_data,
  output logic [31:0]             state_counters
);

  import sgd_defines::*;

  localparam int          ROW_FEATS = ENGINE_NUM * FEATS_PER_BANK;
  localparam int          BPW       = BANK_BITS / BEAT_BITS;
  localparam logic [31:0] BEATS_ROW = 32'(ENGINE_NUM * BPW);

  logic [3:0]  state_q, state_d;
  logic        en_q;
  logic [31:0] dim_q, dim_d;
  logic [31:0] total_q, total_d;
  logic [31:0] len_q, len_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] beats_q, beats_d;
  logic [31:0] sc_q, sc_d;
  logic        start_q, start_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        zero_q, zero_d;

  logic        rise;
  logic        accept;
  logic        last;
  logic        clr;
  logic [31:0] rows_c;
  logic [31:0] total_c;
  logic [31:0] len_c;

  assign rise    = load_x_en & ~en_q;
  assign accept  = ready_q & x_data_in_valid;
  assign last    = accept && (beats_q == total_q - 32'd1);
  assign rows_c  = ceil_div(dim_q, 32'(ROW_FEATS));
  assign total_c = rows_c * BEATS_ROW;
  assign len_c   = total_c << BEAT_BYTES_LOG2;

  always_comb begin
    state_d = state_q;
    dim_d   = dim_q;
    total_d = total_q;
    len_d   = len_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    zero_d  = zero_q;
    start_d = 1'b0;
    ready_d = 1'b0;
    done_d  = 1'b0;
    clr     = 1'b0;
    unique case (1'b1)
      state_q[S_IDLE]: begin
        if (started && rise) begin
          state_d = ST_CMD;
          dim_d   = dimension;
        end
      end
      state_q[S_CMD]: begin
        // an empty model skips the DMA but still signals done
        if (dim_q == 32'd0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          zero_d  = 1'b1;
        end else begin
          state_d = ST_DATA;
          ready_d = 1'b1;
          start_d = 1'b1;
          addr_d  = addr_model;
          len_d   = len_c;
          total_d = total_c;
        end
      end
      state_q[S_DATA]: begin
        ready_d = 1'b1;
        if (accept) begin
          beats_d = beats_q + 32'd1;
          if (last) begin
            state_d = ST_DONE;
            ready_d = 1'b0;
          end
        end
      end
      state_q[S_DONE]: begin
        state_d = ST_IDLE;
        done_d  = ~zero_q;
        zero_d  = 1'b0;
        beats_d = '0;
        clr     = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        clr     = 1'b1;
      end
    endcase
    sc_d = {beats_q[27:0], state_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      dim_q   <= '0;
      total_q <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      beats_q <= '0;
      sc_q    <= '0;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= load_x_en;
      dim_q   <= dim_d;
      total_q <= total_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      sc_q    <= sc_d;
      start_q <= start_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  x_beat_packer #(
    .ENGINE_NUM  (ENGINE_NUM),
    .BANK_BITS   (BANK_BITS),
    .X_ADDR_WIDTH(X_ADDR_WIDTH),
    .BEAT_BITS   (BEAT_BITS)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clr),
    .beat_acc (accept),
    .beat_data(x_data_in),
    .wr_en    (x_mem_wr_en),
    .wr_addr  (x_mem_wr_addr),
    .wr_data  (x_mem_wr_data)
  );

  assign load_x_done      = done_q;
  assign x_data_rd_start  = start_q;
  assign x_data_rd_addr   = addr_q;
  assign x_data_rd_length = len_q;
  assign x_data_in_ready  = ready_q;
  assign state_counters   = sc_q;

endmodule

// File: tb/tb_sgd_rd_x_from_memory.sv
// Directed bench for sgd_rd_x_from_memory: command, packing,
// timing, empty model, reset mid-load and ignored re-requests.
module tb_sgd_rd_x_from_memory;

  localparam int EN = 8;
  localparam int BB = 2048;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          started = 1'b0;
  logic [63:0]   addr_model = '0;
  logic [31:0]   dimension = '0;
  logic          load_x_en = 1'b0;
  logic [511:0]  x_data_in = '0;
  logic          x_data_in_valid = 1'b0;
  logic          load_x_done;
  logic          x_data_rd_start;
  logic [63:0]   x_data_rd_addr;
  logic [31:0]   x_data_rd_length;
  logic          x_data_in_ready;
  logic [EN-1:0] x_mem_wr_en;
  logic [AW-1:0] x_mem_wr_addr;
  logic [BB-1:0] x_mem_wr_data;
  logic [31:0]   state_counters;

  sgd_rd_x_from_memory #(
    .ENGINE_NUM(EN), .BANK_BITS(BB), .X_ADDR_WIDTH(AW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .started         (started),
    .addr_model      (addr_model),
    .dimension       (dimension),
    .load_x_en       (load_x_en),
    .load_x_done     (load_x_done),
    .x_data_rd_start (x_data_rd_start),
    .x_data_rd_addr  (x_data_rd_addr),
    .x_data_rd_length(x_data_rd_length),
    .x_data_in       (x_data_in),
    .x_data_in_valid (x_data_in_valid),
    .x_data_in_ready (x_data_in_ready),
    .x_mem_wr_en     (x_mem_wr_en),
    .x_mem_wr_addr   (x_mem_wr_addr),
    .x_mem_wr_data   (x_mem_wr_data),
    .state_counters  (state_counters)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int n_wr = 0, n_start = 0, n_done = 0, bad_oh = 0;
  int start_cyc = -1, done_cyc = -1, req_cyc = 0;
  logic [EN-1:0] wr_en_log [64];
  logic [AW-1:0] wr_addr_log [64];
  logic [BB-1:0] wr_data_log [64];
  int            wr_cyc_log [64];
  int            acc_cyc [64];

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (x_mem_wr_en != '0) begin
        if (!$onehot(x_mem_wr_en)) bad_oh++;
        if (n_wr < 64) begin
          wr_en_log[n_wr]   = x_mem_wr_en;
          wr_addr_log[n_wr] = x_mem_wr_addr;
          wr_data_log[n_wr] = x_mem_wr_data;
          wr_cyc_log[n_wr]  = cyc;
        end
        n_wr++;
      end
      if (x_data_rd_start) begin
        n_start++;
        start_cyc = cyc;
      end
      if (load_x_done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic [511:0] beat_val(input int k, input int seed);
    logic [31:0] w;
    w = (32'(seed) << 16) | 32'(k);
    return {16{w}};
  endfunction

  function automatic logic [BB-1:0] exp_word(input int w, input int seed);
    logic [BB-1:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[j*512 +: 512] = beat_val(4*w + j, seed);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag, input int nw, input int seed);
    logic [BB-1:0] e;
    check({tag, "_nwr"}, 64'(n_wr), 64'(nw));
    check({tag, "_onehot"}, 64'(bad_oh), 64'd0);
    for (int w = 0; w < nw && w < 64; w++) begin
      e = exp_word(w, seed);
      check($sformatf("%s_en[%0d]", tag, w), 64'(wr_en_log[w]),
            64'd1 << (w % EN));
      check($sformatf("%s_addr[%0d]", tag, w), 64'(wr_addr_log[w]),
            64'(w / EN));
      check($sformatf("%s_wcyc[%0d]", tag, w), 64'(wr_cyc_log[w]),
            64'(acc_cyc[4*w+3] + 1));
      checks++;
      assert (wr_data_log[w] === e) else begin
        errors++;
        $error("FAIL %s_data[%0d]: observed lo %0h hi %0h expected lo %0h hi %0h",
               tag, w, wr_data_log[w][63:0], wr_data_log[w][1599:1536],
               e[63:0], e[1599:1536]);
      end
    end
  endtask

  task automatic start_load(input int dim, input logic [63:0] addr);
    @(negedge clk);
    n_wr = 0; n_start = 0; n_done = 0; bad_oh = 0;
    start_cyc = -1; done_cyc = -1;
    dimension  = 32'(dim);
    addr_model = addr;
    load_x_en  = 1'b1;
    req_cyc    = cyc;
  endtask

  task automatic send_beats(input int n, input int seed, input bit gaps,
                            input int stop_at, input int retrig_at);
    int k = 0;
    int guard = 0;
    int want;
    want = (n < stop_at) ? n : stop_at;
    while (k < want && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (retrig_at >= 0 && k == retrig_at) load_x_en = 1'b0;
      if (retrig_at >= 0 && k == retrig_at + 1) load_x_en = 1'b1;
      if (retrig_at >= 0 && k == retrig_at + 3) started = 1'b0;
      if (gaps && $urandom_range(1, 0) == 0) begin
        x_data_in_valid = 1'b0;
      end else begin
        x_data_in_valid = 1'b1;
        x_data_in = beat_val(k, seed);
        if (x_data_in_ready) begin
          acc_cyc[k] = cyc;
          k++;
        end
      end
    end
    check("beats_sent", 64'(k), 64'(want));
  endtask

  task automatic wait_done();
    int g = 0;
    while (n_done == 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("done_seen", 64'(n_done != 0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(x_data_in_ready), 64'd0);
    check("rst_start", 64'(x_data_rd_start), 64'd0);
    check("rst_addr", x_data_rd_addr, 64'd0);
    check("rst_len", 64'(x_data_rd_length), 64'd0);
    check("rst_done", 64'(load_x_done), 64'd0);
    check("rst_wr_en", 64'(x_mem_wr_en), 64'd0);
    check("rst_wr_addr", 64'(x_mem_wr_addr), 64'd0);
    check("rst_sc", 64'(state_counters), 64'd0);
    checks++;
    assert (x_mem_wr_data === '0) else begin
      errors++;
      $error("FAIL rst_wr_data: observed lo %0h expected 0",
             x_mem_wr_data[63:0]);
    end
    rst_n = 1'b1;
    started = 1'b1;

    // beats offered while idle are never taken
    x_data_in_valid = 1'b1;
    x_data_in = beat_val(9, 9);
    repeat (3) @(negedge clk);
    check("idle_ready", 64'(x_data_in_ready), 64'd0);
    check("idle_nwr", 64'(n_wr), 64'd0);
    x_data_in_valid = 1'b0;

    // dimension 512: one row, 32 beats
    start_load(512, 64'h0000_0012_3456_7000);
    send_beats(32, 1, 1'b0, 1000, -1);
    @(negedge clk);
    x_data_in_valid = 1'b1;
    x_data_in = beat_val(77, 1);
    check("t1_overrun_ready", 64'(x_data_in_ready), 64'd0);
    repeat (3) @(negedge clk);
    x_data_in_valid = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    check("t1_nstart", 64'(n_start), 64'd1);
    check("t1_start_lat", 64'(start_cyc - req_cyc), 64'd2);
    check("t1_rd_addr", x_data_rd_addr, 64'h0000_0012_3456_7000);
    check("t1_rd_len", 64'(x_data_rd_length), 64'd2048);
    check("t1_ndone", 64'(n_done), 64'd1);
    check("t1_done_lat", 64'(done_cyc - acc_cyc[31]), 64'd2);
    check_writes("t1", 8, 1);
    load_x_en = 1'b0;

    // same load with random valid gaps
    start_load(512, 64'h0000_0000_0000_8000);
    send_beats(32, 1, 1'b1, 1000, -1);
    @(negedge clk);
    x_data_in_valid = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    check("t2_nstart", 64'(n_start), 64'd1);
    check("t2_ndone", 64'(n_done), 64'd1);
    check("t2_done_lat", 64'(done_cyc - acc_cyc[31]), 64'd2);
    check_writes("t2", 8, 1);
    load_x_en = 1'b0;

    // dimension 1000: two rows, 64 beats
    start_load(1000, 64'h0000_00AB_0000_0040);
    send_beats(64, 2, 1'b0, 1000, -1);
    @(negedge clk);
    x_data_in_valid = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    check("t3_rd_len", 64'(x_data_rd_length), 64'd4096);
    check("t3_rd_addr", x_data_rd_addr, 64'h0000_00AB_0000_0040);
    check("t3_ndone", 64'(n_done), 64'd1);
    check_writes("t3", 16, 2);
    load_x_en = 1'b0;

    // empty model: no command, done still fires
    start_load(0, 64'h0000_0000_0000_1000);
    wait_done();
    repeat (4) @(negedge clk);
    check("t4_nstart", 64'(n_start), 64'd0);
    check("t4_ndone", 64'(n_done), 64'd1);
    check("t4_done_lat", 64'(done_cyc - req_cyc), 64'd2);
    check("t4_nwr", 64'(n_wr), 64'd0);
    load_x_en = 1'b0;

    // reset after 10 beats, then a clean restart
    start_load(512, 64'h0000_0000_0000_2000);
    send_beats(32, 4, 1'b0, 10, -1);
    @(negedge clk);
    rst_n = 1'b0;
    load_x_en = 1'b0;
    x_data_in_valid = 1'b0;
    @(negedge clk);
    check("t5_rst_ready", 64'(x_data_in_ready), 64'd0);
    check("t5_rst_wr_en", 64'(x_mem_wr_en), 64'd0);
    check("t5_rst_addr", x_data_rd_addr, 64'd0);
    check("t5_rst_len", 64'(x_data_rd_length), 64'd0);
    check("t5_rst_sc", 64'(state_counters), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start_load(512, 64'h0000_0000_0000_3000);
    send_beats(32, 5, 1'b0, 1000, -1);
    @(negedge clk);
    x_data_in_valid = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    check("t5_nstart", 64'(n_start), 64'd1);
    check("t5_rd_len", 64'(x_data_rd_length), 64'd2048);
    check("t5_ndone", 64'(n_done), 64'd1);
    check_writes("t5", 8, 5);
    load_x_en = 1'b0;

    // re-request during DATA is ignored; started drop mid-load
    start_load(512, 64'h0000_0000_0000_4000);
    send_beats(32, 6, 1'b0, 1000, 5);
    @(negedge clk);
    x_data_in_valid = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);
    check("t6_nstart", 64'(n_start), 64'd1);
    check("t6_ndone", 64'(n_done), 64'd1);
    check_writes("t6", 8, 6);
    started = 1'b1;
    load_x_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
